// File: rtl/game_sequencer_if.sv
// ============================================================================
// Module      : game_sequencer_if
// Description : Control/strobe bundle between the game sequencer and the
//               pixel datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_sequencer_if #(
  parameter int NUM_PADDLES = 2,
  parameter int SCORE_W     = 4
);
  logic                   start;
  logic                   frame_tick;
  logic                   done_draw;
  logic                   goal_p1;
  logic                   goal_p2;
  logic                   draw_bounds;
  logic [NUM_PADDLES-1:0] draw_paddle;
  logic                   draw_ball;
  logic                   erase_en;
  logic                   update_en;
  logic                   ball_reset;
  logic [SCORE_W-1:0]     score_p1;
  logic [SCORE_W-1:0]     score_p2;
  logic                   game_over;
  logic                   winner;

  modport master (
    input  start, frame_tick, done_draw, goal_p1, goal_p2,
    output draw_bounds, draw_paddle, draw_ball, erase_en, update_en,
           ball_reset, score_p1, score_p2, game_over, winner
  );

  modport slave (
    output start, frame_tick, done_draw, goal_p1, goal_p2,
    input  draw_bounds, draw_paddle, draw_ball, erase_en, update_en,
           ball_reset, score_p1, score_p2, game_over, winner
  );
endinterface

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// Module      : game_sequencer
// Description : Air-hockey game FSM: draws bounds/paddles/ball, runs the
//               per-frame erase/update/redraw loop, keeps score and serve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
  parameter int NUM_PADDLES  = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 30
) (
  input  wire                     clock,
  input  wire                     reset_n,
  game_sequencer_if.master        seq_io
);

  localparam int IDX_W   = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [IDX_W-1:0]   C_LAST_IDX  = IDX_W'(NUM_PADDLES - 1);
  localparam logic [SCORE_W-1:0] C_WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SERVE_W-1:0] C_SERVE_LEN = SERVE_W'(SERVE_FRAMES);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_BOUNDS     = 4'd1,
    S_PADDLE     = 4'd2,
    S_BALL       = 4'd3,
    S_WAIT_FRAME = 4'd4,
    S_ERASE      = 4'd5,
    S_UPDATE     = 4'd6,
    S_CHECK      = 4'd7,
    S_SERVE      = 4'd8,
    S_OVER       = 4'd9
  } state_t;

  state_t               state_q,  state_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [SERVE_W-1:0]   serve_q,  serve_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic [SCORE_W-1:0]   score2_q, score2_d;
  logic                 winner_q, winner_d;

  logic [SCORE_W-1:0]   score1_inc_w;
  logic [SCORE_W-1:0]   score2_inc_w;

  logic                   draw_bounds_w;
  logic [NUM_PADDLES-1:0] draw_paddle_w;
  logic                   draw_ball_w;
  logic                   erase_en_w;
  logic                   update_en_w;
  logic                   ball_reset_w;
  logic                   game_over_w;

  assign score1_inc_w = (score1_q < C_WIN) ? score1_q + SCORE_W'(1) : score1_q;
  assign score2_inc_w = (score2_q < C_WIN) ? score2_q + SCORE_W'(1) : score2_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      serve_q  <= '0;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      serve_q  <= serve_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    serve_d  = serve_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;

    case (state_q)
      S_IDLE: begin
        if (seq_io.start) state_d = S_BOUNDS;
      end
      S_BOUNDS: begin
        if (seq_io.done_draw) begin
          state_d = S_PADDLE;
          idx_d   = '0;
        end
      end
      S_PADDLE: begin
        if (seq_io.done_draw) begin
          if (idx_q == C_LAST_IDX) state_d = S_BALL;
          else                     idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_BALL: begin
        if (seq_io.done_draw) state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        // Serve hold-off consumes whole frames before the loop resumes
        if (seq_io.frame_tick) begin
          if (serve_q != '0) serve_d = serve_q - SERVE_W'(1);
          else               state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        if (seq_io.done_draw) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        idx_d = '0;
        if (seq_io.goal_p1 && !seq_io.goal_p2) begin
          score1_d = score1_inc_w;
          if (score1_inc_w == C_WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d  = S_SERVE;
          end
        end else if (seq_io.goal_p2 && !seq_io.goal_p1) begin
          score2_d = score2_inc_w;
          if (score2_inc_w == C_WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d  = S_SERVE;
          end
        end else begin
          // Simultaneous goals are void; bounds are never redrawn per frame
          state_d = S_PADDLE;
        end
      end
      S_SERVE: begin
        serve_d = C_SERVE_LEN;
        idx_d   = '0;
        state_d = S_PADDLE;
      end
      S_OVER: begin
        if (seq_io.start) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = S_BOUNDS;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    draw_bounds_w = (state_q == S_BOUNDS);
    draw_paddle_w = '0;
    if (state_q == S_PADDLE) draw_paddle_w = NUM_PADDLES'(1) << idx_q;
    draw_ball_w   = (state_q == S_BALL);
    erase_en_w    = (state_q == S_ERASE);
    update_en_w   = (state_q == S_UPDATE);
    ball_reset_w  = (state_q == S_SERVE);
    game_over_w   = (state_q == S_OVER);
  end

  assign seq_io.draw_bounds = draw_bounds_w;
  assign seq_io.draw_paddle = draw_paddle_w;
  assign seq_io.draw_ball   = draw_ball_w;
  assign seq_io.erase_en    = erase_en_w;
  assign seq_io.update_en   = update_en_w;
  assign seq_io.ball_reset  = ball_reset_w;
  assign seq_io.score_p1    = score1_q;
  assign seq_io.score_p2    = score2_q;
  assign seq_io.game_over   = game_over_w;
  assign seq_io.winner      = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer with a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

  localparam int NP  = 2;
  localparam int SW  = 4;
  localparam int WIN = 7;
  localparam int SF  = 30;

  // {ball_reset, update_en, erase_en, draw_ball, draw_paddle[1:0], draw_bounds}
  localparam logic [6:0] C_NONE   = 7'h00;
  localparam logic [6:0] C_BOUNDS = 7'h01;
  localparam logic [6:0] C_P0     = 7'h02;
  localparam logic [6:0] C_P1     = 7'h04;
  localparam logic [6:0] C_BALL   = 7'h08;
  localparam logic [6:0] C_ERASE  = 7'h10;
  localparam logic [6:0] C_UPDATE = 7'h20;
  localparam logic [6:0] C_SERVE  = 7'h40;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  game_sequencer_if #(.NUM_PADDLES(NP), .SCORE_W(SW)) bus ();

  game_sequencer #(
    .NUM_PADDLES (NP),
    .SCORE_W     (SW),
    .WIN_SCORE   (WIN),
    .SERVE_FRAMES(SF)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .seq_io (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] sb[$];

  int m_s1 = 0;
  int m_s2 = 0;
  int m_serve = 0;
  bit m_over = 1'b0;
  bit m_winner = 1'b0;

  function automatic logic [6:0] strobes();
    return {bus.ball_reset, bus.update_en, bus.erase_en, bus.draw_ball,
            bus.draw_paddle, bus.draw_bounds};
  endfunction

  function automatic bit is_job(input logic [6:0] c);
    return (c == C_BOUNDS) || (c == C_P0) || (c == C_P1) || (c == C_BALL) || (c == C_ERASE);
  endfunction

  // Holds a job 3 cycles (a stray frame_tick inside it must be ignored), then pulses done_draw.
  task automatic job_done(output logic [6:0] held);
    @(negedge clock); bus.frame_tick = 1'b1;
    @(negedge clock); bus.frame_tick = 1'b0; held = strobes(); bus.done_draw = 1'b1;
    @(negedge clock); bus.done_draw = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL reset_strobes obs=%h exp=%h", strobes(), C_NONE); end
    checks++; if (bus.score_p1 !== 4'd0) begin errors++; $display("FAIL reset_score_p1 obs=%0d exp=0", bus.score_p1); end
    checks++; if (bus.score_p2 !== 4'd0) begin errors++; $display("FAIL reset_score_p2 obs=%0d exp=0", bus.score_p2); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over obs=%b exp=0", bus.game_over); end
    checks++; if (bus.winner !== 1'b0) begin errors++; $display("FAIL reset_winner obs=%b exp=0", bus.winner); end
    bus.done_draw = 1'b1; @(negedge clock); bus.done_draw = 1'b0; @(negedge clock);
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL idle_ignores_done obs=%h exp=%h", strobes(), C_NONE); end
  endtask

  task automatic test_start_draw();
    logic [6:0] obs, exp, held;
    m_s1 = 0; m_s2 = 0; m_over = 1'b0;
    sb.push_back(C_BOUNDS); sb.push_back(C_P0); sb.push_back(C_P1); sb.push_back(C_BALL);
    bus.start = 1'b1; @(negedge clock); bus.start = 1'b0;
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL start_game_over obs=%b exp=0", bus.game_over); end
    while (sb.size() > 0) begin
      obs = strobes(); exp = sb.pop_front();
      checks++; if (obs !== exp) begin errors++; $display("FAIL draw_seq obs=%h exp=%h", obs, exp); end
      job_done(held);
      checks++; if (held !== exp) begin errors++; $display("FAIL draw_hold obs=%h exp=%h", held, exp); end
    end
    @(negedge clock);
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL wait_frame_idle obs=%h exp=%h", strobes(), C_NONE); end
    checks++; if ({bus.score_p1, bus.score_p2} !== 8'h00) begin
      errors++; $display("FAIL start_scores obs=%0d/%0d exp=0/0", bus.score_p1, bus.score_p2); end
  endtask

  task automatic frame_cycle(input bit g1, input bit g2);
    logic [6:0] obs, exp, held;
    bus.frame_tick = 1'b1; @(negedge clock); bus.frame_tick = 1'b0;
    if (m_serve > 0) begin
      m_serve--;
      checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL serve_absorb obs=%h exp=%h left=%0d", strobes(), C_NONE, m_serve); end
      @(negedge clock);
      return;
    end
    sb.push_back(C_ERASE); sb.push_back(C_UPDATE); sb.push_back(C_NONE);
    if (g1 ^ g2) begin
      if (g1) begin if (m_s1 < WIN) m_s1++; end
      else    begin if (m_s2 < WIN) m_s2++; end
      if ((g1 ? m_s1 : m_s2) == WIN) begin
        m_over = 1'b1; m_winner = g2;
        sb.push_back(C_NONE);
      end else begin
        m_serve = SF;
        sb.push_back(C_SERVE); sb.push_back(C_P0); sb.push_back(C_P1); sb.push_back(C_BALL);
      end
    end else begin
      sb.push_back(C_P0); sb.push_back(C_P1); sb.push_back(C_BALL);
    end
    bus.goal_p1 = g1; bus.goal_p2 = g2;
    while (sb.size() > 0) begin
      obs = strobes(); exp = sb.pop_front();
      checks++; if (obs !== exp) begin errors++; $display("FAIL frame_seq obs=%h exp=%h g=%b%b", obs, exp, g1, g2); end
      if (is_job(exp)) begin
        job_done(held);
        checks++; if (held !== exp) begin errors++; $display("FAIL frame_hold obs=%h exp=%h", held, exp); end
      end else begin
        @(negedge clock);
      end
    end
    bus.goal_p1 = 1'b0; bus.goal_p2 = 1'b0;
    checks++; if (bus.score_p1 !== SW'(m_s1) || bus.score_p2 !== SW'(m_s2)) begin
      errors++; $display("FAIL scores obs=%0d/%0d exp=%0d/%0d", bus.score_p1, bus.score_p2, m_s1, m_s2); end
    checks++; if (bus.game_over !== m_over) begin errors++; $display("FAIL game_over obs=%b exp=%b", bus.game_over, m_over); end
    if (m_over) begin
      checks++; if (bus.winner !== m_winner) begin errors++; $display("FAIL winner obs=%b exp=%b", bus.winner, m_winner); end
    end
  endtask

  task automatic test_goal_p2();
    frame_cycle(1'b0, 1'b1);
    repeat (SF) frame_cycle(1'b0, 1'b0);
    frame_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_erase();
    while (m_serve > 0) frame_cycle(1'b0, 1'b0);
    bus.frame_tick = 1'b1; @(negedge clock); bus.frame_tick = 1'b0;
    checks++; if (strobes() !== C_ERASE) begin errors++; $display("FAIL pre_reset_erase obs=%h exp=%h", strobes(), C_ERASE); end
    reset_n = 1'b0; @(negedge clock); reset_n = 1'b1;
    m_s1 = 0; m_s2 = 0; m_serve = 0; m_over = 1'b0;
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL mid_reset_strobes obs=%h exp=%h", strobes(), C_NONE); end
    checks++; if ({bus.score_p1, bus.score_p2} !== 8'h00) begin
      errors++; $display("FAIL mid_reset_scores obs=%0d/%0d exp=0/0", bus.score_p1, bus.score_p2); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL mid_reset_over obs=%b exp=0", bus.game_over); end
    bus.done_draw = 1'b1; @(negedge clock); bus.done_draw = 1'b0; @(negedge clock);
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL mid_reset_idle obs=%h exp=%h", strobes(), C_NONE); end
  endtask

  task automatic test_win_p1();
    for (int n = 0; n < WIN + 2 && !m_over; n++) begin
      frame_cycle(1'b1, 1'b0);
      while (m_serve > 0) frame_cycle(1'b0, 1'b0);
    end
    checks++; if (m_over !== 1'b1 || bus.game_over !== 1'b1) begin
      errors++; $display("FAIL win_reached obs=%b exp=1", bus.game_over); end
  endtask

  task automatic test_over_hold();
    bus.done_draw = 1'b1; bus.frame_tick = 1'b1; @(negedge clock);
    bus.done_draw = 1'b0; bus.frame_tick = 1'b0; @(negedge clock);
    checks++; if (strobes() !== C_NONE) begin errors++; $display("FAIL over_strobes obs=%h exp=%h", strobes(), C_NONE); end
    checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL over_hold obs=%b exp=1", bus.game_over); end
    checks++; if (bus.score_p1 !== SW'(WIN)) begin errors++; $display("FAIL over_score_p1 obs=%0d exp=%0d", bus.score_p1, WIN); end
    checks++; if (bus.winner !== 1'b0) begin errors++; $display("FAIL over_winner obs=%b exp=0", bus.winner); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.done_draw = 1'b0;
    bus.goal_p1 = 1'b0; bus.goal_p2 = 1'b0;
    @(negedge clock);
    test_reset();
    test_start_draw();
    frame_cycle(1'b0, 1'b0);
    test_goal_p2();
    frame_cycle(1'b1, 1'b1);
    test_reset_mid_erase();
    test_start_draw();
    test_win_p1();
    test_over_hold();
    test_start_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
